// File: rtl/duty_cycle_display_driver_pkg.sv
// Shared widths, FSM encoding and 7-segment codes for the duty-cycle display driver.
package duty_cycle_display_driver_pkg;

   localparam int BIN_W      = 17;
   localparam int NUM_DIGITS = 6;
   localparam int BCD_W      = 4 * NUM_DIGITS;
   localparam int CNT_W      = 5;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CONVERT,
      ST_COMMIT
   } state_t;

   // Segment order {g,f,e,d,c,b,a}, active-low.
   localparam logic [6:0] SEG_0   = 7'b1000000;
   localparam logic [6:0] SEG_1   = 7'b1111001;
   localparam logic [6:0] SEG_2   = 7'b0100100;
   localparam logic [6:0] SEG_3   = 7'b0110000;
   localparam logic [6:0] SEG_4   = 7'b0011001;
   localparam logic [6:0] SEG_5   = 7'b0010010;
   localparam logic [6:0] SEG_6   = 7'b0000010;
   localparam logic [6:0] SEG_7   = 7'b1111000;
   localparam logic [6:0] SEG_8   = 7'b0000000;
   localparam logic [6:0] SEG_9   = 7'b0010000;
   localparam logic [6:0] SEG_OFF = 7'b1111111;

   localparam logic [NUM_DIGITS-1:0] AN_OFF = '1;

   function automatic logic [6:0] seg_encode(input logic [3:0] digit);
      logic [6:0] s;
      s = SEG_OFF;
      case (digit)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_OFF;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/bin17_to_bcd_seq.sv
// Sequential double-dabble engine: start loads a binary value, each step does
// one add-3/shift; last is high on the step that completes the conversion.
module bin17_to_bcd_seq
   import duty_cycle_display_driver_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [BIN_W-1:0] bin_in,
   input  logic             step,
   output logic [BCD_W-1:0] bcd,
   output logic             last
);

   logic [BIN_W-1:0] bin_sr;
   logic [BCD_W-1:0] bcd_sr;
   logic [BCD_W-2:0] bcd_adj;
   logic [CNT_W-1:0] cnt;

   // The top nibble never exceeds 1 for a 17-bit input, so it needs no adjust.
   always_comb begin
      bcd_adj = bcd_sr[BCD_W-2:0];
      for (int i = 0; i < NUM_DIGITS - 1; i++) begin
         if (bcd_sr[4*i +: 4] >= 4'd5)
            bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
      end
   end

   // NOTE: registers use <= so every flop samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!reset) begin
         bin_sr <= '0;
         bcd_sr <= '0;
         cnt    <= '0;
      end else if (start) begin
         bin_sr <= bin_in;
         bcd_sr <= '0;
         cnt    <= '0;
      end else if (step) begin
         bcd_sr <= {bcd_adj, bin_sr[BIN_W-1]};
         bin_sr <= {bin_sr[BIN_W-2:0], 1'b0};
         cnt    <= cnt + 1'b1;
      end
   end

   assign bcd  = bcd_sr;
   assign last = (cnt == CNT_W'(BIN_W - 1));

endmodule

// File: rtl/duty_cycle_display_driver.sv
// Converts the 17-bit duty-cycle value to decimal and scans it onto a 6-digit
// common-anode display; the shown number only changes on a finished conversion.
module duty_cycle_display_driver
   import duty_cycle_display_driver_pkg::*;
#(
   parameter int REFRESH_DIV   = 100000,
   parameter bit BLANK_LEADING = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [BIN_W-1:0]      value,
   input  logic                  value_valid,
   output logic                  busy,
   output logic [NUM_DIGITS-1:0] an,
   output logic [6:0]            seg,
   output logic                  dp
);

   localparam int PRESC_W = $clog2(REFRESH_DIV);
   localparam int IDX_W   = 3;

   state_t           state, state_nxt;
   logic             pending;
   logic [BIN_W-1:0] pending_val;
   logic             eng_start, eng_step, eng_last, commit;
   logic [BIN_W-1:0] eng_bin;
   logic [BCD_W-1:0] eng_bcd, digit_reg;

   bin17_to_bcd_seq u_conv (
      .clk    (clk),
      .reset  (reset),
      .start  (eng_start),
      .bin_in (eng_bin),
      .step   (eng_step),
      .bcd    (eng_bcd),
      .last   (eng_last)
   );

   // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
   always_comb begin
      state_nxt = state;
      eng_start = 1'b0;
      eng_step  = 1'b0;
      eng_bin   = value;
      commit    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (value_valid) begin
               eng_start = 1'b1;
               state_nxt = ST_CONVERT;
            end
         end
         ST_CONVERT: begin
            eng_step = 1'b1;
            if (eng_last)
               state_nxt = ST_COMMIT;
         end
         ST_COMMIT: begin
            commit = 1'b1;
            // A strobe landing on the commit edge is the newest pending value.
            if (pending || value_valid) begin
               eng_start = 1'b1;
               eng_bin   = value_valid ? value : pending_val;
               state_nxt = ST_CONVERT;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= ST_IDLE;
         pending     <= 1'b0;
         pending_val <= '0;
         digit_reg   <= '0;
      end else begin
         state <= state_nxt;
         if (commit) begin
            digit_reg <= eng_bcd;
            pending   <= 1'b0;
         end else if (value_valid && state == ST_CONVERT) begin
            pending     <= 1'b1;
            pending_val <= value;
         end
      end
   end

   assign busy = (state != ST_IDLE);
   assign dp   = 1'b1;

   logic [PRESC_W-1:0] presc;
   logic [IDX_W-1:0]   idx;
   logic               wrap, cur_blank;
   logic [BCD_W-1:0]   shifted;

   assign wrap    = (presc == PRESC_W'(REFRESH_DIV - 1));
   assign shifted = digit_reg >> {idx, 2'b00};
   // Leading-zero test: this digit and everything above it are zero.
   assign cur_blank = BLANK_LEADING && (idx != '0) && (shifted == '0);

   always_ff @(posedge clk) begin
      if (!reset) begin
         presc <= '0;
         idx   <= '0;
         an    <= AN_OFF;
         seg   <= SEG_OFF;
      end else if (wrap) begin
         presc <= '0;
         idx   <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
         an    <= AN_OFF;
         seg   <= SEG_OFF;
      end else begin
         presc <= presc + 1'b1;
         an    <= ~(NUM_DIGITS'(1) << idx);
         seg   <= cur_blank ? SEG_OFF : seg_encode(shifted[3:0]);
      end
   end

endmodule

// File: tb/tb_duty_cycle_display_driver.sv
// Table-driven bench with a scoreboard queue of expected display frames;
// runs a blanking and a non-blanking instance side by side.
module tb_duty_cycle_display_driver;

   logic        clk = 1'b0;
   logic        reset;
   logic        value_valid;
   logic [16:0] value;
   logic        busy_a, dp_a, busy_b, dp_b;
   logic [5:0]  an_a, an_b;
   logic [6:0]  seg_a, seg_b;

   always #5 clk = ~clk;

   duty_cycle_display_driver #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) dut (
      .clk(clk), .reset(reset), .value(value), .value_valid(value_valid),
      .busy(busy_a), .an(an_a), .seg(seg_a), .dp(dp_a)
   );

   duty_cycle_display_driver #(.REFRESH_DIV(4), .BLANK_LEADING(1'b0)) dut_nb (
      .clk(clk), .reset(reset), .value(value), .value_valid(value_valid),
      .busy(busy_b), .an(an_b), .seg(seg_b), .dp(dp_b)
   );

   // dig holds six hex nibbles, digit 0 in the low nibble; F marks a blanked digit.
   typedef struct packed {
      logic [16:0] value;
      logic [23:0] dig;
   } vec_t;

   vec_t       vecs[8];
   vec_t       sb_q[$];
   int         n_checks = 0;
   int         n_pass   = 0;
   logic [7:0] cap_a[6];
   logic [7:0] cap_b[6];
   bit         scan_ok;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
   endtask

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b1000000;
         4'd1:    return 7'b1111001;
         4'd2:    return 7'b0100100;
         4'd3:    return 7'b0110000;
         4'd4:    return 7'b0011001;
         4'd5:    return 7'b0010010;
         4'd6:    return 7'b0000010;
         4'd7:    return 7'b1111000;
         4'd8:    return 7'b0000000;
         4'd9:    return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   task automatic strobe(input logic [16:0] v);
      @(posedge clk); #1;
      value       = v;
      value_valid = 1'b1;
      @(posedge clk); #1;
      value_valid = 1'b0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy_a && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   // Watch a bit more than one full scan; record each lit digit and verify the
   // anode sequence 0..5 with exactly one all-off cycle between slots.
   task automatic capture();
      int off_run;
      int last_idx;
      int k_idx;
      for (int i = 0; i < 6; i++) begin
         cap_a[i] = 8'hFF;
         cap_b[i] = 8'hFF;
      end
      scan_ok  = 1'b1;
      off_run  = 0;
      last_idx = -1;
      repeat (2) @(posedge clk);
      repeat (32) begin
         @(negedge clk);
         if (an_b !== an_a) scan_ok = 1'b0;
         if (an_a == 6'b111111) begin
            off_run++;
         end else if ($countones(~an_a) == 1) begin
            k_idx = 0;
            for (int k = 0; k < 6; k++) if (!an_a[k]) k_idx = k;
            if (last_idx >= 0 && k_idx != last_idx &&
                (off_run != 1 || k_idx != (last_idx + 1) % 6)) scan_ok = 1'b0;
            if (last_idx >= 0 && k_idx == last_idx && off_run != 0) scan_ok = 1'b0;
            last_idx     = k_idx;
            off_run      = 0;
            cap_a[k_idx] = {1'b0, seg_a};
            cap_b[k_idx] = {1'b0, seg_b};
         end else begin
            scan_ok = 1'b0;
         end
      end
   endtask

   task automatic check_frame(input string tag);
      vec_t       e;
      logic [3:0] d;
      if (sb_q.size() == 0) begin
         n_checks++;
         $display("FAIL %s: scoreboard empty", tag);
         return;
      end
      e = sb_q.pop_front();
      for (int i = 0; i < 6; i++) begin
         d = e.dig[4*i +: 4];
         check($sformatf("%s blank d%0d", tag, i), 32'(cap_a[i]), 32'({1'b0, seg_of(d)}));
         check($sformatf("%s full d%0d", tag, i), 32'(cap_b[i]),
               32'({1'b0, seg_of(d == 4'hF ? 4'h0 : d)}));
      end
      check({tag, " scan"}, 32'(scan_ok), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   n;
      int   k_idx;
      bit   mid_done;
      vec_t e;

      vecs[0] = '{17'd12345,  24'hF12345};
      vecs[1] = '{17'd131071, 24'h131071};
      vecs[2] = '{17'd42,     24'hFFFF42};
      vecs[3] = '{17'd100000, 24'h100000};
      vecs[4] = '{17'd7,      24'hFFFFF7};
      vecs[5] = '{17'd99999,  24'hF99999};
      vecs[6] = '{17'd0,      24'hFFFFF0};
      vecs[7] = '{17'd100,    24'hFFF100};

      reset       = 1'b0;
      value       = '0;
      value_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset an", 32'(an_a), 32'h3F);
      check("reset seg", 32'(seg_a), 32'h7F);
      check("reset dp", 32'(dp_a), 32'd1);
      check("reset busy", 32'(busy_a), 32'd0);
      reset = 1'b1;
      sb_q.push_back('{17'd0, 24'hFFFFF0});
      capture();
      check_frame("after reset");

      for (int v = 0; v < 8; v++) begin
         sb_q.push_back(vecs[v]);
         strobe(vecs[v].value);
         wait_idle(n);
         check($sformatf("busy len %0d", vecs[v].value), 32'(n), 32'd18);
         capture();
         check_frame($sformatf("val %0d", vecs[v].value));
      end

      // Strobe 100, then 200 and 300 while busy: 100 commits, then 300 (last wins).
      sb_q.push_back('{17'd100, 24'hFFF100});
      sb_q.push_back('{17'd300, 24'hFFF300});
      @(posedge clk); #1;
      value = 17'd100;
      value_valid = 1'b1;
      @(posedge clk); #1;
      value = 17'd200;
      @(posedge clk); #1;
      value = 17'd300;
      @(posedge clk); #1;
      value_valid = 1'b0;
      n = 2;
      mid_done = 1'b0;
      while (busy_a && n < 200) begin
         @(posedge clk); #1;
         n++;
         if (!mid_done && n >= 20 && n <= 35 && $countones(~an_a) == 1) begin
            k_idx = 0;
            for (int k = 0; k < 6; k++) if (!an_a[k]) k_idx = k;
            e = sb_q.pop_front();
            check($sformatf("pend first d%0d", k_idx), 32'(seg_a), 32'(seg_of(e.dig[4*k_idx +: 4])));
            mid_done = 1'b1;
         end
      end
      if (!mid_done) begin
         n_checks++;
         $display("FAIL pend first: no lit slot observed between commits");
         void'(sb_q.pop_front());
      end
      check("pend busy len", 32'(n), 32'd36);
      capture();
      check_frame("pend last");

      // Strobe landing exactly on the commit edge behaves like a capture one cycle later.
      sb_q.push_back('{17'd777, 24'hFFF777});
      strobe(17'd555);
      n = 0;
      while (n < 17) begin
         @(posedge clk); #1;
         n++;
      end
      value = 17'd777;
      value_valid = 1'b1;
      @(posedge clk); #1;
      value_valid = 1'b0;
      n = 18;
      while (busy_a && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      check("collide busy len", 32'(n), 32'd36);
      capture();
      check_frame("collide");

      // Reset at E9 aborts the conversion and clears the display to a single 0.
      strobe(17'd99999);
      repeat (8) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk); #1;
      check("abort busy", 32'(busy_a), 32'd0);
      check("abort an", 32'(an_a), 32'h3F);
      reset = 1'b1;
      sb_q.push_back('{17'd0, 24'hFFFFF0});
      capture();
      check_frame("abort");
      repeat (30) @(posedge clk);
      #1;
      check("abort stays idle", 32'(busy_a), 32'd0);
      sb_q.push_back('{17'd0, 24'hFFFFF0});
      capture();
      check_frame("no late commit");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/duty_cycle_display_driver.md
Name: duty_cycle_display_driver

Overview:
- Downstream consumer of the duty-cycle measurement circuit; takes its 17-bit unsigned `value` and shows it in decimal on a 6-digit multiplexed common-anode 7-segment display.
- Conversion uses a sequential double-dabble engine, one bit per clock.
- Scanning is time-multiplexed by a programmable prescaler.
- The displayed number changes only on a completed conversion, so the display never shows partial results.

Parameters:
- REFRESH_DIV, 100000, clocks per digit slot (legal range 2..2^20); bench uses 4.
- BLANK_LEADING, 1, 1 = blank leading zeros (digit 0 always lit); 0 = show all six digits.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- value  in  17  unsigned binary from duty-cycle circuit, 0..131071
- value_valid  in  1  single-cycle strobe: sample `value` and convert
- busy  out  1  conversion in progress
- an  out  6  digit anodes, active-low one-hot, an[0] = least significant digit
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low, held 1 (off)

Behaviour:
- Reset (reset==0 at a clk edge):
  - an=6'b111111, seg=7'b1111111, dp=1, busy=0.
  - digit_reg all 0, scan index 0, prescaler 0, state IDLE, pending=0.
  - Reset mid-conversion aborts the conversion; digit_reg returns to 0.
- FSM states: IDLE, CONVERT, COMMIT.
  - IDLE: on value_valid=1 at edge E0, capture value into bin_sr, clear bcd_sr (24 bits), cnt=0, go to CONVERT; busy=1 from E0.
  - CONVERT, edges E1..E17:
    - Add 3 to every BCD nibble >=5.
    - Shift {bcd_sr,bin_sr} left by 1.
    - cnt increments; after cnt==16 go to COMMIT.
  - COMMIT, edge E18: digit_reg <= bcd_sr, busy=0. If pending=1, recapture the pending value and go to CONVERT; otherwise go to IDLE.
  - Fixed latency: 18 clocks from capture edge to digit_reg update.
- value_valid while busy:
  - Latch `value` into pending_val and set pending=1.
  - A later strobe overwrites pending_val (last wins).
  - At most one conversion is queued; strobes are never lost except by overwrite.
- Simultaneous value_valid and COMMIT: the new value becomes pending and is consumed by that COMMIT. Result is identical to capture one cycle later.
- Scan:
  - Prescaler counts 0..REFRESH_DIV-1.
  - On wrap, index increments 0..5 and wraps 5->0.
  - an and seg are registered from index/digit_reg, so they update 1 clock after index changes.
  - an is driven 6'b111111 for that one cycle (ghosting guard), then the new one-hot.
- Blanking (BLANK_LEADING=1): digit i (i>=1) is blanked (seg=7'b1111111) when digits i..5 are all 0. Value 0 shows a single "0".
- Segment codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any nibble >9 maps to all-off (unreachable by construction).
- Width rules:
  - 17-bit input needs 6 BCD digits.
  - Max 131071 gives digits 1,3,1,0,7,1; no overflow path exists.

Decomposition:
- Shared package: BIN_W=17, NUM_DIGITS=6, BCD_W=24, FSM state enum, SEG_* code constants, SEG_OFF.
- One sub-module, bin17_to_bcd_seq: the FSM-free shift/add-3 engine with start/done interface. The top module holds the FSM, pending logic, scan and decode.

Test Plan:
- Reset release, no strobe, REFRESH_DIV=4 -> busy=0; only an[0] active, seg=1000000; digits 1..5 blank.
- value=12345 strobe -> busy high 18 clocks.
  - Scan shows an[0]:0010010 (5), an[1]:0011001 (4), an[2]:0110000 (3), an[3]:0100100 (2), an[4]:1111001 (1).
  - an[5] slot has seg=1111111.
- value=131071 -> digits 1,7,0,1,3,1 from an[0] to an[5]; all six lit; inner 0 (an[2]) shown as 1000000, not blanked.
- Strobe 100 at E0, then strobes 200 and 300 during busy -> display shows 100 after E18, then 300 at E36; 200 is never displayed.
- Strobe 99999, assert reset at E9 -> busy=0; display returns to single "0"; no later commit of 99999.
- BLANK_LEADING=0 with value=42 -> an[5..0] show 0,0,0,0,4,2; one all-off cycle on every index change.
